// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: sequential fetch from a word-addressed
// instruction memory into a single-entry output stage, with redirect,
// EBREAK halt/resume and an end-of-memory fault state.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        resume,
    output logic [7:0]  imem_addr,
    input  logic [31:0] imem_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        halted,
    output logic        fault,
    output logic        misalign
);

    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        slot_free_c;
    logic        in_range_c;
    logic        fetch_c;
    logic        clear_c;

    assign imem_addr   = pc[9:2];
    assign slot_free_c = !out_valid || out_ready;
    assign in_range_c  = (pc < PC_LIMIT);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: redirect overrides everything, then resume, then EBREAK/fault.
    always_comb begin
        state_next = state;
        if (redirect_valid) begin
            state_next = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (slot_free_c) begin
                        if (!in_range_c) begin
                            state_next = ST_FAULT;
                        end else if (imem_data == EBREAK) begin
                            state_next = ST_HALT;
                        end
                    end
                end
                ST_HALT: begin
                    if (resume) begin
                        state_next = ST_RUN;
                    end
                end
                ST_FAULT: begin
                    state_next = ST_FAULT;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    // Output decode: fetch only in RUN with a free slot and an in-range pc.
    always_comb begin
        fetch_c = 1'b0;
        clear_c = 1'b0;
        if (redirect_valid) begin
            clear_c = 1'b1;
        end else if (state == ST_RUN && slot_free_c && in_range_c) begin
            fetch_c = 1'b1;
        end else if (slot_free_c) begin
            clear_c = 1'b1;
        end
    end

    // Datapath: pc, output stage and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            out_valid <= 1'b0;
            out_instr <= 32'h0;
            out_pc    <= 32'h0;
            misalign  <= 1'b0;
            halted    <= 1'b0;
            fault     <= 1'b0;
        end else begin
            if (redirect_valid) begin
                pc <= {redirect_pc[31:2], 2'b00};
            end else if (fetch_c) begin
                pc <= pc + 32'd4;
            end

            if (fetch_c) begin
                out_valid <= 1'b1;
                out_instr <= imem_data;
                out_pc    <= pc;
            end else if (clear_c) begin
                out_valid <= 1'b0;
            end

            misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
            halted   <= (state_next == ST_HALT);
            fault    <= (state_next == ST_FAULT);
        end
    end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter IMEM_WORDS, default 256, instruction memory depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect_valid  input  1  branch/jump redirect request, single-cycle pulse.
REQ-006 redirect_pc  input  32  redirect target byte address.
REQ-007 resume  input  1  leave HALT and continue fetching.
REQ-008 imem_addr  output  8  word address to the instruction memory.
REQ-009 imem_data  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-010 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-011 out_ready  input  1  downstream accepts the output this cycle.
REQ-012 out_instr  output  32  fetched instruction.
REQ-013 out_pc  output  32  byte address of out_instr.
REQ-014 halted  output  1  high while in HALT.
REQ-015 fault  output  1  high while in FAULT.
REQ-016 misalign  output  1  one-cycle pulse on a redirect with redirect_pc[1:0] != 0.

Function
REQ-017 Internal 32-bit pc register; imem_addr SHALL equal pc[9:2] combinationally.
REQ-018 States: RUN, HALT, FAULT; transitions only on a rising clock edge.
REQ-019 Output stage: "slot free" SHALL mean !out_valid || out_ready.
REQ-020 RUN, slot free, pc < 4*IMEM_WORDS, no redirect: out_instr<=imem_data, out_pc<=pc, out_valid<=1, pc<=pc+4; one instruction per cycle at full throughput.
REQ-021 RUN, slot not free: pc, out_instr, out_pc and out_valid SHALL hold unchanged.
REQ-022 RUN, slot free, no fetch issued this cycle: out_valid<=0.
REQ-023 Captured instruction == 32'h0010_0073 (EBREAK): it SHALL be issued normally, then state<=HALT; no further fetch; pc holds the EBREAK address + 4.
REQ-024 HALT: no fetch; a pending output SHALL still drain via out_ready; resume=1 -> RUN, fetch resumes at pc the next cycle.
REQ-025 RUN, slot free, pc >= 4*IMEM_WORDS: no fetch; state<=FAULT; pc holds.
REQ-026 FAULT: no fetch; exit only via redirect or rst.
REQ-027 redirect_valid=1 in any state: out_valid<=0 (pending output discarded), pc<={redirect_pc[31:2],2'b00}, state<=RUN; the first fetch from the new pc occurs the following cycle.
REQ-028 Misaligned redirect: the low bits SHALL be cleared per REQ-027 and misalign pulsed for exactly that cycle.
REQ-029 Priority: rst > redirect_valid > resume > EBREAK/fault detection > normal fetch.
REQ-030 redirect_valid in the same cycle as an EBREAK capture: the redirect wins, no HALT is entered, and the EBREAK is discarded.
REQ-031 pc+4 SHALL be 32-bit modular; imem_addr is never wrapped silently, because REQ-025 triggers first.

Reset
REQ-032 rst=1 at a clock edge: pc<=RESET_PC, state<=RUN, out_valid<=0, out_instr<=0, out_pc<=0, misalign<=0.
REQ-033 While rst=1: halted=0, fault=0, no output is presented.
REQ-034 rst asserted mid-stream or in HALT/FAULT SHALL discard all state; the first fetch SHALL occur in the first cycle with rst=0.

Verification
REQ-035 Sequential fetch: memory words 0-3 = A0..A3, out_ready=1 -> out_pc 0,4,8,12 with instructions A0..A3 on consecutive cycles, out_valid=1 from the cycle after rst drops.
REQ-036 Backpressure: out_ready=0 for 3 cycles while out_pc=4 -> out_pc/out_instr held for all 3 cycles, no skipped or duplicated pc when out_ready returns to 1.
REQ-037 Redirect: redirect_valid with redirect_pc=0x23 while out_valid=1 -> next cycle out_valid=0 and misalign=1; the cycle after that, out_pc=0x20.
REQ-038 EBREAK: word 5 = 32'h00100073 -> out_pc=0x14 issued, then halted=1 and no new output; resume=1 -> next output out_pc=0x18.
REQ-039 End of memory: RESET_PC=0x3F8 -> out_pc 0x3F8, 0x3FC, then fault=1 with out_valid=0; redirect_pc=0 -> fault=0, next output out_pc=0.
REQ-040 Simultaneous events: redirect_valid and resume in the same cycle in HALT -> RUN at the redirect target; rst mid-stream -> out_valid=0 and restart at RESET_PC.
